uart_tx_resposta: RTL and testbench
===================================

# uart_tx_resposta

Downstream consumer of the DHT11 controller's response buffer. The block waits for `bufferPronto` and captures the 16-bit `info` word. It serialises the word over a UART TX line as two 8N1 frames, high byte first. After the last stop bit it pulses `bufferUsado` so the controller can reset and accept the next command.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 2.
- `clk`  input  1: system clock; all logic on rising edge.
- `reset_n`  input  1: synchronous, active-low reset.
- `bufferPronto`  input  1: level from controller; `info` is valid while high.
- `info`  input  16: response word to transmit.
- `tx`  output  1: UART serial line, idle high.
- `bufferUsado`  output  1: one-cycle pulse; response fully transmitted.
- `ocupado`  output  1: high from capture until return to IDLE.

## Operation
- Registers:
  - `shift[15:0]` holds the captured word.
  - `baud_cnt` counts 0..CLKS_PER_BIT-1.
  - `bit_idx` counts 0..7.
  - `byte_idx` counts 0..1.
- States: IDLE, START, DATA, STOP, ACK, WAIT_LOW.
- IDLE:
  - `tx`=1, `ocupado`=0.
  - If `bufferPronto`=1: latch `info` into `shift`, clear counters, set `ocupado`=1, go to START.
- START:
  - `tx`=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with `bit_idx`=0.
- DATA:
  - `tx` = bit `bit_idx` of the current byte, LSB first.
  - Byte 0 is `shift[15:8]`; byte 1 is `shift[7:0]`.
  - Each bit lasts CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - If `byte_idx`=0: increment `byte_idx` and go to START. There is no idle gap between frames.
  - Else go to ACK.
- ACK:
  - `bufferUsado`=1 for exactly one cycle.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - `tx`=1, `ocupado`=1.
  - Stay until `bufferPronto`=0, then go to IDLE.
  - This prevents retransmitting a stale word, because the controller drops `bufferPronto` one cycle after seeing `bufferUsado`.
- `info` changes after capture are ignored; only the latched copy is sent.
- `bufferPronto` falling mid-transmission is ignored; the transmission completes and `bufferUsado` still pulses.
- `baud_cnt` wraps to 0 at CLKS_PER_BIT-1 and advances the bit position on that same cycle.

## Timing
- Reset values: `tx`=1, `bufferUsado`=0, `ocupado`=0, state=IDLE, all counters 0.
- `reset_n` low at any edge forces those values on that edge:
  - A frame in progress is abandoned: `tx` returns high immediately and no `bufferUsado` pulse occurs.
  - Reset has priority over every transition.
- `tx`, `bufferUsado` and `ocupado` are registered outputs.
- Capture at edge E, where `bufferPronto`=1 is sampled in IDLE:
  - `tx` goes low and `ocupado` goes high after edge E.
  - Byte 0 start bit occupies cycles E+1 .. E+CLKS_PER_BIT.
- Each frame is 10·CLKS_PER_BIT cycles; the response is 20·CLKS_PER_BIT cycles.
- `bufferUsado` is high in cycle E+20·CLKS_PER_BIT+1 only.
- Earliest next capture is the first edge after `bufferPronto` is sampled low in WAIT_LOW, plus one cycle in IDLE.
- If `bufferPronto` is already 0 when WAIT_LOW is entered, IDLE is reached on the next edge.

## Test plan
- Reset idle (CLKS_PER_BIT=4): hold `reset_n`=0 for 3 cycles, then release with `bufferPronto`=0 → `tx`=1, `bufferUsado`=0, `ocupado`=0 for 50 cycles.
- Single response (`info`=16'h00A5, CLKS_PER_BIT=4), `bufferPronto` raised at cycle 0 and dropped 1 cycle after `bufferUsado`:
  - `tx` per 4-cycle bit: 0, 0×8, 1, then 0, 1,0,1,0,0,1,0,1, 1.
  - `bufferUsado` high only at cycle 81; `ocupado` low again by cycle 83.
- Input stability: after capture of 16'h1234, change `info` to 16'hFFFF → line still carries 0x34-0x12 bit patterns (byte 0x12 first, then 0x34).
- Held `bufferPronto`: keep it high for 40 cycles after `bufferUsado` → exactly one transmission and one pulse; block stays in WAIT_LOW with `tx`=1 until `bufferPronto` falls.
- Reset mid-frame: assert `reset_n`=0 during DATA of byte 1 → `tx`=1 on that edge, no `bufferUsado` pulse; a later `bufferPronto` starts a clean transmission from byte 0.
- Back-to-back responses: 16'hC3F0, then 16'h0F0F after `bufferPronto` toggles low/high → two complete 20-bit sequences, two `bufferUsado` pulses, no merged frames.

Source files
------------

// File: rtl/uart_tx_resposta.sv
// uart_tx_resposta: sends a captured 16-bit response as two 8N1 UART frames, high byte first, then pulses bufferUsado
module uart_tx_resposta #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bufferPronto,
  input  logic [15:0] info,
  output logic        tx,
  output logic        bufferUsado,
  output logic        ocupado
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ACK, WAIT_LOW} state_t;
  state_t        state;
  logic [15:0]   shift;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          byte_idx;
  logic [7:0]    cur_byte;
  logic          bit_end;
  always_comb begin
    cur_byte = byte_idx ? shift[7:0] : shift[15:8];
    bit_end  = baud_cnt == LAST;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx          <= 1'b1;
      bufferUsado <= 1'b0;
      ocupado     <= 1'b0;
      shift       <= '0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= 1'b0;
    end else begin
      bufferUsado <= 1'b0;
      if (state == START || state == DATA || state == STOP)
        baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          ocupado <= 1'b0;
          if (bufferPronto) begin
            shift    <= info;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            ocupado  <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: if (bit_end) begin
          bit_idx <= '0;
          tx      <= cur_byte[0];
          state   <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= cur_byte[bit_idx + 3'd1];
          end
        end
        STOP: if (bit_end) begin
          if (!byte_idx) begin
            byte_idx <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end else begin
            bufferUsado <= 1'b1;
            state       <= ACK;
          end
        end
        ACK: state <= WAIT_LOW;
        WAIT_LOW: begin
          tx <= 1'b1;
          if (!bufferPronto) begin
            ocupado <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_resposta.sv
// tb_uart_tx_resposta: table-driven check of the UART response transmitter with CLKS_PER_BIT=4
module tb_uart_tx_resposta;
  localparam int C = 4;
  logic        clk;
  logic        reset_n;
  logic        bufferPronto;
  logic [15:0] info;
  logic        tx;
  logic        bufferUsado;
  logic        ocupado;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [15:0] info;
    logic [15:0] info_after;
    int          hold;
    logic [0:19] exp;
  } vec_t;
  vec_t vecs[4];
  uart_tx_resposta #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bufferPronto(bufferPronto),
    .info(info),
    .tx(tx),
    .bufferUsado(bufferUsado),
    .ocupado(ocupado)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // Cycle c is the negedge sample after the c-th rising edge following the capture edge.
  task automatic send(input vec_t v);
    logic [0:19] line;
    int pulses;
    int first;
    logic wait_ok;
    logic ocup_up;
    line = '0;
    pulses = 0;
    first = -1;
    wait_ok = 1'b1;
    ocup_up = 1'b0;
    info = v.info;
    bufferPronto = 1'b1;
    for (int c = 1; c <= 82 + v.hold; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ocup_up = ocupado;
        info = v.info_after;
      end
      if (c <= 20 * C && (c - 2) % C == 0) line[(c - 2) / C] = tx;
      if (bufferUsado === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c > 20 * C && tx !== 1'b1) wait_ok = 1'b0;
      if (c == 81 + v.hold) begin
        check("ocupado_hold", {31'b0, ocupado}, 1);
        bufferPronto = 1'b0;
      end
    end
    check("ocupado_up", {31'b0, ocup_up}, 1);
    check("ocupado_down", {31'b0, ocupado}, 0);
    check("line", {12'b0, line}, {12'b0, v.exp});
    check("pulse_count", pulses, 1);
    check("pulse_cycle", first, 20 * C + 1);
    check("wait_tx_high", {31'b0, wait_ok}, 1);
  endtask
  initial begin
    int errs;
    int pulses;
    vecs[0] = '{16'h00A5, 16'h00A5, 1,  20'b0_00000000_1_0_10100101_1};
    vecs[1] = '{16'h1234, 16'hFFFF, 1,  20'b0_01001000_1_0_00101100_1};
    vecs[2] = '{16'hC3F0, 16'hC3F0, 40, 20'b0_11000011_1_0_00001111_1};
    vecs[3] = '{16'h0F0F, 16'h0F0F, 1,  20'b0_11110000_1_0_11110000_1};
    reset_n = 1'b0;
    bufferPronto = 1'b0;
    info = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 1);
    check("reset_usado", {31'b0, bufferUsado}, 0);
    check("reset_ocupado", {31'b0, ocupado}, 0);
    reset_n = 1'b1;
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || bufferUsado !== 1'b0 || ocupado !== 1'b0) errs++;
    end
    check("idle_50", errs, 0);
    for (int i = 0; i < 4; i++) begin
      send(vecs[i]);
      repeat (2) @(negedge clk);
    end
    info = 16'h0000;
    bufferPronto = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_frame_tx_low", {31'b0, tx}, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_tx", {31'b0, tx}, 1);
    check("midreset_ocupado", {31'b0, ocupado}, 0);
    check("midreset_usado", {31'b0, bufferUsado}, 0);
    reset_n = 1'b1;
    bufferPronto = 1'b0;
    errs = 0;
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || ocupado !== 1'b0) errs++;
      if (bufferUsado === 1'b1) pulses++;
    end
    check("after_reset_idle", errs, 0);
    check("after_reset_no_pulse", pulses, 0);
    send(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
